// File: rtl/operand_bypass_net_if.sv
// Handshake-free bundle between the EX-stage sources, M/W producers and the bypass net.
// The master side drives the pipeline view; the slave side is the bypass net.
interface operand_bypass_net_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int NSRC  = 2,
    parameter int REGW  = 5
);
    logic                         stall_i;
    logic [LANES*NSRC-1:0]        e_src_valid_i;
    logic [LANES*NSRC*REGW-1:0]   e_rs_i;
    logic [LANES*NSRC*XLEN-1:0]   e_rf_data_i;
    logic [LANES-1:0]             m_valid_i;
    logic [LANES-1:0]             m_is_load_i;
    logic [LANES*REGW-1:0]        m_rd_i;
    logic [LANES*XLEN-1:0]        m_result_i;
    logic [LANES-1:0]             w_valid_i;
    logic [LANES*REGW-1:0]        w_rd_i;
    logic [LANES*XLEN-1:0]        w_result_i;
    logic [LANES*NSRC*XLEN-1:0]   e_operand_o;
    logic [LANES*NSRC*2-1:0]      e_fwd_sel_o;
    logic                         load_use_stall_o;

    modport master (
        output stall_i,
        output e_src_valid_i,
        output e_rs_i,
        output e_rf_data_i,
        output m_valid_i,
        output m_is_load_i,
        output m_rd_i,
        output m_result_i,
        output w_valid_i,
        output w_rd_i,
        output w_result_i,
        input  e_operand_o,
        input  e_fwd_sel_o,
        input  load_use_stall_o
    );

    modport slave (
        input  stall_i,
        input  e_src_valid_i,
        input  e_rs_i,
        input  e_rf_data_i,
        input  m_valid_i,
        input  m_is_load_i,
        input  m_rd_i,
        input  m_result_i,
        input  w_valid_i,
        input  w_rd_i,
        input  w_result_i,
        output e_operand_o,
        output e_fwd_sel_o,
        output load_use_stall_o
    );
endinterface

// File: rtl/operand_bypass_net.sv
// Superscalar EX operand bypass: M > W > retired history > RF, plus load-use stall.
// Optional BYPASS_STATS_EN adds saturating forwarding / load-use counters.
module operand_bypass_net #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int NSRC  = 2,
    parameter int REGW  = 5,
    parameter int HIST  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    operand_bypass_net_if.slave bus
`ifdef BYPASS_STATS_EN
    ,
    output logic [31:0]         stat_fwd_m_o,
    output logic [31:0]         stat_fwd_w_o,
    output logic [31:0]         stat_ldu_o
`endif
);

    localparam int SRCS = LANES * NSRC;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_WH = 2'b01;
    localparam logic [1:0] SEL_M  = 2'b10;

    typedef logic [LANES-1:0][REGW-1:0] rd_vec_t;
    typedef logic [LANES-1:0][XLEN-1:0] dat_vec_t;

    typedef struct packed {
        logic [1:0]      sel;
        logic            ld;
        logic [XLEN-1:0] data;
    } pick_t;

    logic [LANES-1:0]            m_vld;
    logic [LANES-1:0]            m_ld;
    rd_vec_t                     m_rd;
    dat_vec_t                    m_res;
    logic [LANES-1:0]            w_vld;
    rd_vec_t                     w_rd;
    dat_vec_t                    w_res;
    logic [SRCS-1:0]             src_vld;
    logic [SRCS-1:0][REGW-1:0]   src_rs;
    logic [SRCS-1:0][XLEN-1:0]   src_rf;

    assign m_vld   = bus.m_valid_i;
    assign m_ld    = bus.m_is_load_i;
    assign m_rd    = bus.m_rd_i;
    assign m_res   = bus.m_result_i;
    assign w_vld   = bus.w_valid_i;
    assign w_rd    = bus.w_rd_i;
    assign w_res   = bus.w_result_i;
    assign src_vld = bus.e_src_valid_i;
    assign src_rs  = bus.e_rs_i;
    assign src_rf  = bus.e_rf_data_i;

    // Retired-write history, entry 0 newest
    logic [LANES-1:0] hv_q   [HIST];
    logic [LANES-1:0] hv_d   [HIST];
    rd_vec_t          hrd_q  [HIST];
    rd_vec_t          hrd_d  [HIST];
    dat_vec_t         hdat_q [HIST];
    dat_vec_t         hdat_d [HIST];

    always_comb begin
        for (int k = 0; k < HIST; k++) begin
            hv_d[k]   = hv_q[k];
            hrd_d[k]  = hrd_q[k];
            hdat_d[k] = hdat_q[k];
        end
        if (!bus.stall_i) begin
            hv_d[0]   = w_vld;
            hrd_d[0]  = w_rd;
            hdat_d[0] = w_res;
            for (int k = 1; k < HIST; k++) begin
                hv_d[k]   = hv_q[k-1];
                hrd_d[k]  = hrd_q[k-1];
                hdat_d[k] = hdat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HIST; k++) begin
                hv_q[k]   <= '0;
                hrd_q[k]  <= '0;
                hdat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < HIST; k++) begin
                hv_q[k]   <= hv_d[k];
                hrd_q[k]  <= hrd_d[k];
                hdat_q[k] <= hdat_d[k];
            end
        end
    end

    // First match wins; a load hit in M still blocks older producers.
    function automatic pick_t resolve(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] rf
    );
        pick_t p;
        logic  hit;
        p.sel  = SEL_RF;
        p.ld   = 1'b0;
        p.data = rf;
        hit    = (rs == '0);
        for (int l = LANES - 1; l >= 0; l--) begin
            if (!hit && m_vld[l] && m_rd[l] == rs) begin
                hit    = 1'b1;
                p.sel  = SEL_M;
                p.ld   = m_ld[l];
                p.data = m_res[l];
            end
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            if (!hit && w_vld[l] && w_rd[l] == rs) begin
                hit    = 1'b1;
                p.sel  = SEL_WH;
                p.data = w_res[l];
            end
        end
        for (int k = 0; k < HIST; k++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (!hit && hv_q[k][l] && hrd_q[k][l] == rs) begin
                    hit    = 1'b1;
                    p.sel  = SEL_WH;
                    p.data = hdat_q[k][l];
                end
            end
        end
        return p;
    endfunction

    pick_t [SRCS-1:0]           pk;
    logic  [SRCS-1:0][XLEN-1:0] op;
    logic  [SRCS-1:0][1:0]      sel;
    logic  [SRCS-1:0]           ld_hit;

    always_comb begin
        pk     = '0;
        op     = '0;
        sel    = '0;
        ld_hit = '0;
        for (int s = 0; s < SRCS; s++) begin
            pk[s]     = resolve(src_rs[s], src_rf[s]);
            op[s]     = pk[s].data;
            sel[s]    = pk[s].sel;
            ld_hit[s] = (pk[s].sel == SEL_M) && pk[s].ld;
        end
    end

    assign bus.e_operand_o      = op;
    assign bus.e_fwd_sel_o      = sel;
    assign bus.load_use_stall_o = |(ld_hit & src_vld);

`ifdef BYPASS_STATS_EN
    localparam int CW = $clog2(SRCS + 1);

    logic [CW-1:0] n_m;
    logic [CW-1:0] n_w;
    logic [31:0]   cnt_m_q, cnt_m_d;
    logic [31:0]   cnt_w_q, cnt_w_d;
    logic [31:0]   cnt_l_q, cnt_l_d;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        n_m = '0;
        n_w = '0;
        for (int s = 0; s < SRCS; s++) begin
            if (src_vld[s] && sel[s] == SEL_M && !ld_hit[s])
                n_m = n_m + CW'(1);
            if (src_vld[s] && sel[s] == SEL_WH)
                n_w = n_w + CW'(1);
        end
    end

    always_comb begin
        cnt_m_d = cnt_m_q;
        cnt_w_d = cnt_w_q;
        cnt_l_d = cnt_l_q;
        if (!bus.stall_i) begin
            cnt_m_d = sat_add(cnt_m_q, 32'(n_m));
            cnt_w_d = sat_add(cnt_w_q, 32'(n_w));
            cnt_l_d = sat_add(cnt_l_q, 32'(bus.load_use_stall_o));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m_q <= '0;
            cnt_w_q <= '0;
            cnt_l_q <= '0;
        end else begin
            cnt_m_q <= cnt_m_d;
            cnt_w_q <= cnt_w_d;
            cnt_l_q <= cnt_l_d;
        end
    end

    assign stat_fwd_m_o = cnt_m_q;
    assign stat_fwd_w_o = cnt_w_q;
    assign stat_ldu_o   = cnt_l_q;
`endif

endmodule

// File: tb/tb_operand_bypass_net.sv
// Directed bench for operand_bypass_net: vector table plus history/reset sequences.
module tb_operand_bypass_net;

    localparam logic [127:0] RF = {32'hF3, 32'hF2, 32'hF1, 32'hF0};

    typedef struct packed {
        logic [1:0]        mv;
        logic [1:0]        mld;
        logic [4:0]        mrd0;
        logic [4:0]        mrd1;
        logic [31:0]       mres0;
        logic [31:0]       mres1;
        logic [1:0]        wv;
        logic [4:0]        wrd0;
        logic [4:0]        wrd1;
        logic [31:0]       wres0;
        logic [31:0]       wres1;
        logic [3:0]        sv;
        logic [3:0][4:0]   rs;
        logic [3:0][31:0]  eop;
        logic [3:0]        opm;
        logic [7:0]        esel;
        logic              estall;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    vec_t tbl [12];
    vec_t v;

    operand_bypass_net_if ifc ();

`ifdef BYPASS_STATS_EN
    logic [31:0] st_m, st_w, st_l;
`endif

    operand_bypass_net dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
`ifdef BYPASS_STATS_EN
        ,
        .stat_fwd_m_o (st_m),
        .stat_fwd_w_o (st_w),
        .stat_ldu_o   (st_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t d, input logic st);
        ifc.stall_i       = st;
        ifc.m_valid_i     = d.mv;
        ifc.m_is_load_i   = d.mld;
        ifc.m_rd_i        = {d.mrd1, d.mrd0};
        ifc.m_result_i    = {d.mres1, d.mres0};
        ifc.w_valid_i     = d.wv;
        ifc.w_rd_i        = {d.wrd1, d.wrd0};
        ifc.w_result_i    = {d.wres1, d.wres0};
        ifc.e_src_valid_i = d.sv;
        ifc.e_rs_i        = d.rs;
        ifc.e_rf_data_i   = RF;
    endtask

    function automatic logic [31:0] op(input int s);
        return ifc.e_operand_o[s*32 +: 32];
    endfunction

    function automatic logic [31:0] sel(input int s);
        return 32'(ifc.e_fwd_sel_o[s*2 +: 2]);
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl[0]  = '{2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'hF,{5'd4,5'd3,5'd2,5'd1},RF,4'hF,8'h00,1'b0};
        tbl[1]  = '{2'b01,2'b00,5'd0,5'd0,32'hDEAD,32'h0,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'hF,{5'd0,5'd0,5'd0,5'd0},RF,4'hF,8'h00,1'b0};
        tbl[2]  = '{2'b11,2'b00,5'd5,5'd5,32'h11,32'h22,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'hF,{5'd6,5'd6,5'd6,5'd5},{32'hF3,32'hF2,32'hF1,32'h22},
                    4'hF,8'b00_00_00_10,1'b0};
        tbl[3]  = '{2'b01,2'b00,5'd7,5'd0,32'h70,32'h0,2'b01,5'd7,5'd0,32'h77,32'h0,
                    4'hF,{5'd1,5'd1,5'd7,5'd7},{32'hF3,32'hF2,32'h70,32'h70},
                    4'hF,8'b00_00_10_10,1'b0};
        tbl[4]  = '{2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,2'b01,5'd7,5'd0,32'h77,32'h0,
                    4'hF,{5'd1,5'd1,5'd7,5'd7},{32'hF3,32'hF2,32'h77,32'h77},
                    4'hF,8'b00_00_01_01,1'b0};
        tbl[5]  = '{2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,2'b11,5'd8,5'd8,32'h80,32'h81,
                    4'hF,{5'd1,5'd8,5'd1,5'd1},{32'hF3,32'h81,32'hF1,32'hF0},
                    4'hF,8'b00_01_00_00,1'b0};
        tbl[6]  = '{2'b01,2'b00,5'd9,5'd0,32'h90,32'h0,2'b10,5'd0,5'd9,32'h0,32'h99,
                    4'hF,{5'd9,5'd1,5'd1,5'd1},{32'h90,32'hF2,32'hF1,32'hF0},
                    4'hF,8'b10_00_00_00,1'b0};
        tbl[7]  = '{2'b01,2'b01,5'd3,5'd0,32'h0,32'h0,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'b0001,{5'd1,5'd1,5'd1,5'd3},RF,4'b1110,8'b00_00_00_10,1'b1};
        tbl[8]  = '{2'b01,2'b01,5'd3,5'd0,32'h0,32'h0,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'b0000,{5'd1,5'd1,5'd1,5'd3},RF,4'b1110,8'b00_00_00_10,1'b0};
        tbl[9]  = '{2'b10,2'b10,5'd0,5'd3,32'h0,32'h0,2'b01,5'd3,5'd0,32'h33,32'h0,
                    4'b1000,{5'd3,5'd1,5'd1,5'd1},RF,4'b0111,8'b10_00_00_00,1'b1};
        tbl[10] = '{2'b11,2'b01,5'd3,5'd3,32'h0,32'h44,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'hF,{5'd1,5'd1,5'd1,5'd3},{32'hF3,32'hF2,32'hF1,32'h44},
                    4'hF,8'b00_00_00_10,1'b0};
        tbl[11] = '{2'b01,2'b00,5'd6,5'd0,32'h66,32'h0,2'b00,5'd0,5'd0,32'h0,32'h0,
                    4'b0000,{5'd6,5'd1,5'd1,5'd1},{32'h66,32'hF2,32'hF1,32'hF0},
                    4'hF,8'b10_00_00_00,1'b0};

        // Reset state: history empty, all sources from RF
        rst_n = 1'b0;
        drive(tbl[0], 1'b1);
        #1;
        for (int s = 0; s < 4; s++) chk($sformatf("rst op%0d", s), op(s), RF[s*32 +: 32]);
        chk("rst sel", 32'(ifc.e_fwd_sel_o), 32'h0);
        chk("rst stall", 32'(ifc.load_use_stall_o), 32'h0);
`ifdef BYPASS_STATS_EN
        chk("rst stat_m", st_m, 32'h0);
        chk("rst stat_w", st_w, 32'h0);
        chk("rst stat_l", st_l, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational vectors with history frozen empty
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i], 1'b1);
            #1;
            for (int s = 0; s < 4; s++)
                if (tbl[i].opm[s])
                    chk($sformatf("v%0d op%0d", i, s), op(s), tbl[i].eop[s]);
            chk($sformatf("v%0d sel", i), 32'(ifc.e_fwd_sel_o), 32'(tbl[i].esel));
            chk($sformatf("v%0d stall", i), 32'(ifc.load_use_stall_o), 32'(tbl[i].estall));
        end

        // History capture then drop with HIST=1
        v = '0; v.wv = 2'b01; v.wrd0 = 5'd9; v.wres0 = 32'hAB;
        v.rs = {5'd1, 5'd1, 5'd1, 5'd9}; v.sv = 4'hF;
        @(negedge clk); drive(v, 1'b0);
        v.wv = 2'b00;
        @(negedge clk); drive(v, 1'b0); ifc.e_rf_data_i[31:0] = 32'h0;
        #1;
        chk("hist op", op(0), 32'hAB);
        chk("hist sel", sel(0), 32'h1);
        @(negedge clk); drive(v, 1'b0); ifc.e_rf_data_i[31:0] = 32'h0;
        #1;
        chk("hist drop op", op(0), 32'h0);
        chk("hist drop sel", sel(0), 32'h0);

        // Stall holds history
        v.wv = 2'b01;
        @(negedge clk); drive(v, 1'b0);
        v.wv = 2'b00;
        @(negedge clk); drive(v, 1'b1); ifc.e_rf_data_i[31:0] = 32'h0;
        @(negedge clk); #1;
        chk("hist hold op", op(0), 32'hAB);
        chk("hist hold sel", sel(0), 32'h1);
        v.wv = 2'b01; v.wres0 = 32'hCD;
        drive(v, 1'b1); ifc.e_rf_data_i[31:0] = 32'h0;
        #1;
        chk("w over hist", op(0), 32'hCD);

        // Within one history entry the higher lane wins
        v = '0; v.wv = 2'b11; v.wrd0 = 5'd10; v.wrd1 = 5'd10;
        v.wres0 = 32'hA0; v.wres1 = 32'hA1; v.rs = {5'd1, 5'd1, 5'd1, 5'd10};
        @(negedge clk); drive(v, 1'b0);
        v.wv = 2'b00;
        @(negedge clk); drive(v, 1'b1);
        #1;
        chk("hist tie op", op(0), 32'hA1);
        chk("hist tie sel", sel(0), 32'h1);

        // Async reset clears history mid-cycle
        v = '0; v.wv = 2'b01; v.wrd0 = 5'd4; v.wres0 = 32'h4444;
        v.rs = {5'd1, 5'd1, 5'd1, 5'd4};
        @(negedge clk); drive(v, 1'b0);
        v.wv = 2'b00;
        @(negedge clk); drive(v, 1'b1);
        #1;
        chk("pre-rst op", op(0), 32'h4444);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst op", op(0), 32'hF0);
        chk("mid-rst sel", sel(0), 32'h0);
`ifdef BYPASS_STATS_EN
        chk("mid-rst stat_w", st_w, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        v = '0;
        drive(v, 1'b0);

`ifdef BYPASS_STATS_EN
        v = '0; v.mv = 2'b01; v.mrd0 = 5'd7; v.mres0 = 32'h70;
        v.wv = 2'b01; v.wrd0 = 5'd8; v.wres0 = 32'h80;
        v.rs = {5'd1, 5'd8, 5'd7, 5'd7}; v.sv = 4'b0111;
        @(negedge clk); drive(v, 1'b0);
        v = '0;
        @(negedge clk); drive(v, 1'b1);
        #1;
        chk("stat_m", st_m, 32'd2);
        chk("stat_w", st_w, 32'd1);
        chk("stat_l", st_l, 32'd0);
        v.mv = 2'b01; v.mld = 2'b01; v.mrd0 = 5'd3;
        v.rs = {5'd1, 5'd1, 5'd1, 5'd3}; v.sv = 4'b0001;
        @(negedge clk); drive(v, 1'b0);
        v = '0;
        @(negedge clk); drive(v, 1'b1);
        #1;
        chk("stat_l ld", st_l, 32'd1);
        chk("stat_m ld", st_m, 32'd2);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
